zcash_verif_equihash_tree: RTL and testbench
============================================

// Module: zcash_verif_equihash_tree
// PURPOSE
// - Parametrised equihash (N,K) tree checker. Consumes the 2^K solution leaves in order,
//   each an index plus its N-bit expanded Blake2b hash slice, and folds them bottom-up.
// - At every node it checks the collision bits (XOR) and the index ordering.
// - Sits after the Blake2b hash stage in the equihash verifier; its mask is OR-ed into the verifier mask.
// - Duplicate-index and difficulty checks are not done here.
// PARAMETERS
// - N        200            hash width per leaf, bits
// - K        9              tree depth; leaves per solution = 2^K
// - CBL      N/(K+1)        collision bit length
// - IDX_BITS CBL+1          index width
// PORTS
// - i_clk      in   1         clock
// - i_rst      in   1         synchronous active-high reset
// - i_val      in   1         leaf valid
// - o_rdy      out  1         leaf ready; a leaf transfers when i_val && o_rdy
// - i_idx      in   IDX_BITS  leaf index
// - i_hash     in   N         leaf hash slice; MSB = first collision bit
// - i_last     in   1         final leaf of the solution
// - o_mask     out  3         [0] XOR_FAIL, [1] ORDER_FAIL, [2] COUNT_FAIL
// - o_mask_val out  1         one-cycle pulse; o_mask is valid in this cycle
// BEHAVIOUR
// - Reset: o_rdy=0, o_mask=0, o_mask_val=0, stack empty, leaf count=0, sticky flags clear, FSM=ACCEPT.
//   o_rdy rises the cycle after i_rst deasserts.
// - Stack: K+1 entries, each {lvl[$clog2(K+1)], xr[N], idx[IDX_BITS]}; sp counts valid entries.
// - FSM ACCEPT:
//   - o_rdy=1. On transfer, push {0, i_hash, i_idx} and increment the leaf count.
//   - If the new top two entries have equal lvl, go to MERGE. Else, if the last leaf was taken, go to DONE.
// - FSM MERGE:
//   - o_rdy=0. One merge per cycle; left = entry sp-2, right = entry sp-1.
//   - New entry is {L+1, left.xr^right.xr, left.idx}; it replaces both entries (sp decrements).
//   - XOR_FAIL if xr[N-1 -: (L+1)*CBL] != 0. When L+1==K, require all N bits to be zero.
//   - ORDER_FAIL if left.idx >= right.idx (unsigned).
//   - Stay in MERGE while the new top two levels are equal. Otherwise go to DONE if the last leaf was taken, else to ACCEPT.
// - FSM DONE:
//   - o_mask_val=1 for one cycle; o_mask = sticky flags.
//   - Then clear the flags, leaf count and stack; return to ACCEPT.
// - COUNT_FAIL:
//   - Set if i_last arrives with count != 2^K, or a leaf arrives after count reaches 2^K.
//   - Excess leaves are consumed and discarded (never pushed) until i_last, then go to DONE.
//   - On i_last with count < 2^K: go to DONE with the unmerged stack discarded.
// - Flags are sticky per solution; checking continues after a failure so the full mask is reported.
// - Latency: the last leaf is accepted at cycle t. With a full tree there are K merge cycles,
//   so o_mask_val is high at t+K+1.
// - Throughput: one leaf per ACCEPT cycle; a full solution takes about 2^(K+1) cycles.
// - i_rst at any cycle aborts the current solution; no o_mask_val is produced for it.
// - When i_last and count==2^K, the final merge is always into lvl K; sp=1 at DONE.
// - Widths: the lvl compare is unsigned. The XOR mask (L+1)*CBL is computed from constants via an
//   N-bit mask table indexed by lvl; there is no runtime multiply.
// STRUCTURE
// - zcash_verif_pkg holds:
//   - equihash_tree_ent_t, the stack-entry struct parametrised via N/K/IDX_BITS localparams.
//   - The mask bit positions XOR_FAIL=0, ORDER_FAIL=1, COUNT_FAIL=2.
//   - The function that builds the per-level collision mask.
// - Sub-module zcash_equihash_node_merge (combinational):
//   - Inputs: left, right entries.
//   - Outputs: merged entry, xor_fail, order_fail.
// - The top level holds the stack registers, FSM, counter and sticky flags.
// TESTING (N=12, K=2, CBL=4, 4 leaves; hash hex)
// - Pass: idx 0,1,2,3; hash 123,124,456,451 -> o_mask=3'b000, one o_mask_val pulse, 3 merges total.
// - XOR fail: as Pass but leaf 3 hash=351 -> level-1 xor=107, o_mask=3'b001.
// - Order fail: idx 1,0,2,3, same hashes -> o_mask=3'b010. Swapping the pairs (idx 2,3,0,1) -> 3'b010 at the root merge.
// - Count fail:
//   - i_last on the 3rd leaf -> o_mask[2]=1.
//   - 5 leaves with i_last on the 5th -> o_mask[2]=1, the 5th leaf is consumed, exactly one o_mask_val pulse.
// - Backpressure: i_val held high throughout Pass.
//   - o_rdy is low for 1 cycle after leaf 1 and for 2 cycles after leaf 3.
//   - o_mask_val is high exactly K+1=3 cycles after the last leaf transfer.
// - Reset mid-op: assert i_rst after leaf 2, then send a clean Pass solution -> single o_mask_val pulse, o_mask=3'b000.
// - Back-to-back: Pass then XOR-fail with no gap -> o_mask 3'b000 then 3'b001; flags do not leak across solutions.

Source files
------------

// File: rtl/zcash_verif_pkg.sv
// Shared types and constants for the equihash tree checker.
package zcash_verif_pkg;

    // Default equihash configuration
    localparam int unsigned EQ_N        = 200;
    localparam int unsigned EQ_K        = 9;
    localparam int unsigned EQ_CBL      = EQ_N / (EQ_K + 1);
    localparam int unsigned EQ_IDX_BITS = EQ_CBL + 1;
    localparam int unsigned EQ_LVL_BITS = $clog2(EQ_K + 1);

    // Stack entry at the default configuration; modules built with other N/K
    // declare a local struct with the same field order.
    typedef struct packed {
        logic [EQ_LVL_BITS-1:0] lvl;
        logic [EQ_N-1:0]        xr;
        logic [EQ_IDX_BITS-1:0] idx;
    } equihash_tree_ent_t;

    // Result mask bit positions
    localparam int unsigned XOR_FAIL   = 0;
    localparam int unsigned ORDER_FAIL = 1;
    localparam int unsigned COUNT_FAIL = 2;
    localparam int unsigned MASK_W     = 3;

    // Widest hash the mask builder supports
    localparam int unsigned MASK_MAX_N = 1024;

    typedef enum logic [1:0] {
        StAccept,
        StMerge,
        StDone
    } tree_state_e;

    // Collision mask for a node at level lvl: the top lvl*cbl bits of an n-bit
    // hash, or all n bits at the root level k.
    function automatic logic [MASK_MAX_N-1:0] coll_mask(input int unsigned n,
                                                        input int unsigned cbl,
                                                        input int unsigned k,
                                                        input int unsigned lvl);
        int unsigned            w;
        logic [MASK_MAX_N-1:0] ones;
        w    = (lvl >= k) ? n : lvl * cbl;
        if (w > n) w = n;
        ones = '1;
        return (ones << (n - w)) & ~(ones << n);
    endfunction

endpackage

// File: rtl/zcash_equihash_node_merge.sv
// Combinational merge of two sibling tree nodes with collision and order checks.
module zcash_equihash_node_merge
    import zcash_verif_pkg::*;
#(
    parameter int unsigned N        = EQ_N,
    parameter int unsigned K        = EQ_K,
    parameter int unsigned CBL      = N / (K + 1),
    parameter int unsigned IDX_BITS = CBL + 1,
    parameter int unsigned LW       = $clog2(K + 1),
    parameter int unsigned ENT_W    = LW + N + IDX_BITS
) (
    input  logic [ENT_W-1:0] i_left,
    input  logic [ENT_W-1:0] i_right,
    output logic [ENT_W-1:0] o_merged,
    output logic             o_xor_fail,
    output logic             o_order_fail
);

    localparam int unsigned LV_NUM = 1 << LW;

    typedef struct packed {
        logic [LW-1:0]       lvl;
        logic [N-1:0]        xr;
        logic [IDX_BITS-1:0] idx;
    } ent_t;

    ent_t         w_l;
    ent_t         w_r;
    ent_t         w_m;
    logic [N-1:0] w_mask_tab [LV_NUM];
    logic         w_unused_rlvl;

    // Per-level collision masks; unreachable levels above K check every bit
    for (genvar g = 0; g < LV_NUM; g++) begin : g_mask
        localparam logic [MASK_MAX_N-1:0] LVL_MASK = coll_mask(N, CBL, K, g);
        assign w_mask_tab[g] = LVL_MASK[N-1:0];
    end

    assign w_l = i_left;
    assign w_r = i_right;

    assign w_m.lvl = w_l.lvl + LW'(1);
    assign w_m.xr  = w_l.xr ^ w_r.xr;
    assign w_m.idx = w_l.idx;

    assign o_merged     = w_m;
    assign o_xor_fail   = |(w_m.xr & w_mask_tab[w_m.lvl]);
    assign o_order_fail = (w_l.idx >= w_r.idx);

    // Siblings always share a level, so the right level is not needed
    assign w_unused_rlvl = ^w_r.lvl;

endmodule

// File: rtl/zcash_verif_equihash_tree.sv
// Equihash (N,K) tree checker: stacks leaves, folds equal-level pairs and
// reports a sticky per-solution fail mask.
module zcash_verif_equihash_tree
    import zcash_verif_pkg::*;
#(
    parameter int unsigned N        = EQ_N,
    parameter int unsigned K        = EQ_K,
    parameter int unsigned CBL      = N / (K + 1),
    parameter int unsigned IDX_BITS = CBL + 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_val,
    output logic                o_rdy,
    input  logic [IDX_BITS-1:0] i_idx,
    input  logic [N-1:0]        i_hash,
    input  logic                i_last,
    output logic [MASK_W-1:0]   o_mask,
    output logic                o_mask_val
);

    localparam int unsigned LW    = $clog2(K + 1);
    localparam int unsigned DEPTH = K + 1;
    localparam int unsigned SIW   = $clog2(DEPTH);
    localparam int unsigned SPW   = $clog2(DEPTH + 1);
    localparam int unsigned CW    = K + 1;

    localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
    localparam logic [SPW-1:0] SP_TWO   = SPW'(2);
    localparam logic [SPW-1:0] SP_THREE = SPW'(3);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  LEAVES   = CW'(1) << K;

    typedef struct packed {
        logic [LW-1:0]       lvl;
        logic [N-1:0]        xr;
        logic [IDX_BITS-1:0] idx;
    } ent_t;

    tree_state_e       r_state;
    tree_state_e       w_state_n;
    ent_t              r_stk [DEPTH];
    logic [SPW-1:0]    r_sp;
    logic [CW-1:0]     r_cnt;
    logic [MASK_W-1:0] r_flags;
    logic              r_last;
    logic              r_live;

    logic              w_xfer;
    logic              w_full;
    logic [CW-1:0]     w_cnt_inc;
    ent_t              w_leaf;
    ent_t              w_left;
    ent_t              w_right;
    logic [LW-1:0]     w_below_lvl;
    ent_t              w_merged;
    logic              w_xor_fail;
    logic              w_order_fail;
    logic              w_push_eq;
    logic              w_merge_eq;

    assign o_rdy      = r_live && (r_state == StAccept);
    assign o_mask_val = (r_state == StDone);
    assign o_mask     = o_mask_val ? r_flags : '0;

    assign w_xfer    = i_val && o_rdy;
    assign w_full    = (r_cnt == LEAVES);
    assign w_cnt_inc = r_cnt + CNT_ONE;
    assign w_leaf    = {LW'(0), i_hash, i_idx};

    // Read the top three stack slots; empty slots read as zero
    always_comb begin
        w_left      = '0;
        w_right     = '0;
        w_below_lvl = '0;
        if (r_sp >= SP_ONE)   w_right     = r_stk[SIW'(r_sp - SP_ONE)];
        if (r_sp >= SP_TWO)   w_left      = r_stk[SIW'(r_sp - SP_TWO)];
        if (r_sp >= SP_THREE) w_below_lvl = r_stk[SIW'(r_sp - SP_THREE)].lvl;
    end

    // A pushed leaf pairs with a level-0 top; a merged node pairs with an
    // equal-level entry below it
    assign w_push_eq  = (r_sp >= SP_ONE) && (w_right.lvl == '0);
    assign w_merge_eq = (r_sp >= SP_THREE) && (w_below_lvl == w_merged.lvl);

    zcash_equihash_node_merge #(
        .N        (N),
        .K        (K),
        .CBL      (CBL),
        .IDX_BITS (IDX_BITS)
    ) u_merge (
        .i_left       (w_left),
        .i_right      (w_right),
        .o_merged     (w_merged),
        .o_xor_fail   (w_xor_fail),
        .o_order_fail (w_order_fail)
    );

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StAccept;
        else       r_state <= w_state_n;
    end

    // FSM next-state
    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            StAccept: begin
                if (w_xfer) begin
                    if (w_full) begin
                        // Excess leaf: drop it, finish only on the last one
                        if (i_last) w_state_n = StDone;
                    end else if (i_last && (w_cnt_inc != LEAVES)) begin
                        // Short solution: the partial stack is discarded
                        w_state_n = StDone;
                    end else if (w_push_eq) begin
                        w_state_n = StMerge;
                    end else if (i_last) begin
                        w_state_n = StDone;
                    end
                end
            end
            StMerge: begin
                if (!w_merge_eq) w_state_n = r_last ? StDone : StAccept;
            end
            StDone:  w_state_n = StAccept;
            default: w_state_n = StAccept;
        endcase
    end

    // Stack storage: push a leaf or replace the top pair with its merge
    always_ff @(posedge i_clk) begin
        if (r_state == StAccept && w_xfer && !w_full) begin
            r_stk[SIW'(r_sp)] <= w_leaf;
        end else if (r_state == StMerge) begin
            r_stk[SIW'(r_sp - SP_TWO)] <= w_merged;
        end
    end

    // Stack pointer, leaf counter, last-seen and sticky fail flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp    <= '0;
            r_cnt   <= '0;
            r_flags <= '0;
            r_last  <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            unique case (r_state)
                StAccept: begin
                    if (w_xfer) begin
                        if (w_full) begin
                            r_flags[COUNT_FAIL] <= 1'b1;
                        end else begin
                            r_sp  <= r_sp + SP_ONE;
                            r_cnt <= w_cnt_inc;
                            if (i_last && (w_cnt_inc != LEAVES)) r_flags[COUNT_FAIL] <= 1'b1;
                        end
                        if (i_last) r_last <= 1'b1;
                    end
                end
                StMerge: begin
                    r_sp                <= r_sp - SP_ONE;
                    r_flags[XOR_FAIL]   <= r_flags[XOR_FAIL] | w_xor_fail;
                    r_flags[ORDER_FAIL] <= r_flags[ORDER_FAIL] | w_order_fail;
                end
                StDone: begin
                    r_sp    <= '0;
                    r_cnt   <= '0;
                    r_flags <= '0;
                    r_last  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zcash_verif_equihash_tree.sv
// Bench for zcash_verif_equihash_tree at N=12, K=2: directed cases plus
// randomized solutions against a block-wise tree model.
module tb_zcash_verif_equihash_tree;

    localparam int unsigned N      = 12;
    localparam int unsigned K      = 2;
    localparam int unsigned CBL    = N / (K + 1);
    localparam int unsigned IW     = CBL + 1;
    localparam int unsigned LEAVES = 1 << K;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_val;
    logic          o_rdy;
    logic [IW-1:0] i_idx;
    logic [N-1:0]  i_hash;
    logic          i_last;
    logic [2:0]    o_mask;
    logic          o_mask_val;

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         n_pulse = 0;
    int         n_exp = 0;
    int         last_pulse_cyc = 0;
    logic [2:0] last_mask = '0;
    logic [2:0] exp_q [$];
    bit         rdy_hist [4096];
    logic [IW-1:0] sol_idx [8];
    logic [N-1:0]  sol_hash [8];
    int            xc [8];

    always #5 clk = ~clk;

    zcash_verif_equihash_tree #(
        .N (N),
        .K (K)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_val      (i_val),
        .o_rdy      (o_rdy),
        .i_idx      (i_idx),
        .i_hash     (i_hash),
        .i_last     (i_last),
        .o_mask     (o_mask),
        .o_mask_val (o_mask_val)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record ready history and score every mask pulse in order
    always @(negedge clk) begin
        rdy_hist[cyc % 4096] = o_rdy;
        if (o_mask_val === 1'b1) begin
            n_pulse++;
            last_pulse_cyc = cyc;
            last_mask = o_mask;
            if (exp_q.size() == 0) check_eq("extra_pulse", 32'(n_pulse), 32'(n_exp));
            else check_eq("mask", 32'(o_mask), 32'(exp_q.pop_front()));
        end
    end

    // Expected mask for the first m leaves of sol_*: every aligned block whose
    // leaves all arrived before the fold stops is merged and checked.
    function automatic logic [2:0] model_mask(input int m);
        logic [2:0]   r;
        logic [N-1:0] x;
        int           span;
        int           bs;
        int           w;
        r = '0;
        if (m != LEAVES) r[2] = 1'b1;
        span = (m >= LEAVES) ? LEAVES : m - 1;
        for (int l = 1; l <= K; l++) begin
            bs = 1 << l;
            for (int b = 0; (b + 1) * bs <= span; b++) begin
                x = '0;
                for (int j = 0; j < bs; j++) x ^= sol_hash[b * bs + j];
                w = (l == K) ? N : l * CBL;
                if ((x >> (N - w)) != 0) r[0] = 1'b1;
                if (sol_idx[b * bs] >= sol_idx[b * bs + bs / 2]) r[1] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic set_sol(input logic [IW-1:0] a, input logic [IW-1:0] b,
                           input logic [IW-1:0] c, input logic [IW-1:0] d,
                           input logic [N-1:0] h0, input logic [N-1:0] h1,
                           input logic [N-1:0] h2, input logic [N-1:0] h3);
        sol_idx[0] = a;  sol_idx[1] = b;  sol_idx[2] = c;  sol_idx[3] = d;
        sol_hash[0] = h0; sol_hash[1] = h1; sol_hash[2] = h2; sol_hash[3] = h3;
        sol_idx[4] = 5'd9;
        sol_hash[4] = 12'h5a5;
    endtask

    // Random solution, mostly valid, with occasional order or collision faults
    task automatic gen_sol();
        int           v;
        int           a;
        int           b;
        logic [IW-1:0] t;
        logic [N-1:0] top;
        v = 0;
        for (int i = 0; i < 5; i++) begin
            v += $urandom_range(1, 6);
            sol_idx[i] = IW'(v);
        end
        if ($urandom % 4 == 0) begin
            a = $urandom % 4;
            b = $urandom % 4;
            t = sol_idx[a]; sol_idx[a] = sol_idx[b]; sol_idx[b] = t;
        end
        top = ~({N{1'b1}} >> CBL);
        sol_hash[0] = N'($urandom);
        sol_hash[1] = (sol_hash[0] & top) | (N'($urandom) & ~top);
        sol_hash[2] = N'($urandom);
        sol_hash[3] = sol_hash[0] ^ sol_hash[1] ^ sol_hash[2];
        sol_hash[4] = N'($urandom);
        if ($urandom % 3 == 0) begin
            a = $urandom % 4;
            sol_hash[a][$urandom % N] ^= 1'b1;
        end
    endtask

    // Present one leaf and wait (bounded) for it to transfer; xo is the
    // negedge cycle count of the transfer cycle
    task automatic send_leaf(input logic [IW-1:0] idx, input logic [N-1:0] h,
                             input logic last, output int xo);
        int wn;
        wn = 0;
        xo = -1;
        i_val = 1'b1; i_idx = idx; i_hash = h; i_last = last;
        while (wn < 200) begin
            @(negedge clk);
            if (o_rdy === 1'b1) begin
                xo = cyc;
                @(posedge clk);
                #1;
                break;
            end
            wn++;
        end
        if (xo < 0) check_eq("rdy_timeout", 32'(wn), 32'(0));
    endtask

    task automatic send_solution(input int m, input bit gaps, input bit hold);
        exp_q.push_back(model_mask(m));
        n_exp++;
        for (int i = 0; i < m; i++) begin
            send_leaf(sol_idx[i], sol_hash[i], (i == m - 1), xc[i]);
            if (gaps && (i != m - 1) && ($urandom % 2 == 1)) begin
                i_val = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        if (!hold) begin
            i_val  = 1'b0;
            i_last = 1'b0;
        end
    endtask

    task automatic wait_pulses(input int target);
        int wn;
        wn = 0;
        while (n_pulse < target && wn < 100) begin
            @(negedge clk);
            wn++;
        end
        if (n_pulse < target) check_eq("pulse_timeout", 32'(n_pulse), 32'(target));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int m;
        int rm [6] = '{3, 4, 4, 4, 4, 5};
        rst = 1'b1; i_val = 1'b0; i_idx = '0; i_hash = '0; i_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rdy", 32'(o_rdy), 32'(0));
        check_eq("rst_mask", 32'(o_mask), 32'(0));
        check_eq("rst_mask_val", 32'(o_mask_val), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rdy_first_cycle", 32'(o_rdy), 32'(0));
        @(negedge clk);
        check_eq("rdy_rises", 32'(o_rdy), 32'(1));
        @(posedge clk); #1;

        // Pass with i_val held high: ready gaps and latency
        set_sol(5'd0, 5'd1, 5'd2, 5'd3, 12'h123, 12'h124, 12'h456, 12'h451);
        p0 = n_pulse;
        send_solution(4, 1'b0, 1'b0);
        wait_pulses(p0 + 1);
        check_eq("pass_mask", 32'(last_mask), 32'(3'b000));
        check_eq("pass_pulses", 32'(n_pulse), 32'(p0 + 1));
        check_eq("gap_l0_l1", 32'(xc[1] - xc[0]), 32'(1));
        check_eq("gap_l1_l2", 32'(xc[2] - xc[1]), 32'(2));
        check_eq("rdy_low_after_l1", 32'(rdy_hist[(xc[1] + 1) % 4096]), 32'(0));
        check_eq("gap_l2_l3", 32'(xc[3] - xc[2]), 32'(1));
        check_eq("rdy_low_l3_c1", 32'(rdy_hist[(xc[3] + 1) % 4096]), 32'(0));
        check_eq("rdy_low_l3_c2", 32'(rdy_hist[(xc[3] + 2) % 4096]), 32'(0));
        check_eq("latency", 32'(last_pulse_cyc - xc[3]), 32'(K + 1));

        // Collision failure
        set_sol(5'd0, 5'd1, 5'd2, 5'd3, 12'h123, 12'h124, 12'h456, 12'h351);
        send_solution(4, 1'b0, 1'b0);
        wait_pulses(n_exp);
        check_eq("xor_mask", 32'(last_mask), 32'(3'b001));

        // Order failures at level 1 and at the root
        set_sol(5'd1, 5'd0, 5'd2, 5'd3, 12'h123, 12'h124, 12'h456, 12'h451);
        send_solution(4, 1'b0, 1'b0);
        wait_pulses(n_exp);
        check_eq("order_l1_mask", 32'(last_mask), 32'(3'b010));
        set_sol(5'd2, 5'd3, 5'd0, 5'd1, 12'h123, 12'h124, 12'h456, 12'h451);
        send_solution(4, 1'b0, 1'b0);
        wait_pulses(n_exp);
        check_eq("order_root_mask", 32'(last_mask), 32'(3'b010));

        // Short and long solutions
        set_sol(5'd0, 5'd1, 5'd2, 5'd3, 12'h123, 12'h124, 12'h456, 12'h451);
        send_solution(3, 1'b0, 1'b0);
        wait_pulses(n_exp);
        check_eq("short_mask", 32'(last_mask), 32'(3'b100));
        p0 = n_pulse;
        send_solution(5, 1'b0, 1'b0);
        wait_pulses(n_exp);
        check_eq("long_mask", 32'(last_mask), 32'(3'b100));
        check_eq("long_pulses", 32'(n_pulse), 32'(p0 + 1));

        // Reset mid-solution, then a clean solution
        p0 = n_pulse;
        for (int i = 0; i < 3; i++) send_leaf(sol_idx[i], sol_hash[i], 1'b0, xc[i]);
        i_val = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_rdy", 32'(o_rdy), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        send_solution(4, 1'b0, 1'b0);
        wait_pulses(n_exp);
        check_eq("midrst_mask", 32'(last_mask), 32'(3'b000));
        check_eq("midrst_pulses", 32'(n_pulse), 32'(p0 + 1));

        // Back-to-back: pass then collision failure with no idle gap
        send_solution(4, 1'b0, 1'b1);
        set_sol(5'd0, 5'd1, 5'd2, 5'd3, 12'h123, 12'h124, 12'h456, 12'h351);
        send_solution(4, 1'b0, 1'b0);
        wait_pulses(n_exp);
        check_eq("b2b_second_mask", 32'(last_mask), 32'(3'b001));

        // Randomized solutions
        for (int s = 0; s < 40; s++) begin
            gen_sol();
            m = rm[$urandom % 6];
            send_solution(m, bit'($urandom % 2), ($urandom % 4 == 0));
        end
        i_val = 1'b0;
        i_last = 1'b0;
        wait_pulses(n_exp);
        check_eq("exp_drained", 32'(exp_q.size()), 32'(0));
        check_eq("pulse_total", 32'(n_pulse), 32'(n_exp));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
